// File: rtl/mma_pkg.sv
// rtl/mma_pkg.sv - shared types and index helpers for the systolic matrix-multiply core
package mma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int drain_cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

    function automatic int c_index(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mma_pe.sv
// rtl/mma_pe.sv - one output-stationary processing element: forwards a/b, multiply-accumulates in place
module mma_pe
    import mma_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sign_mode,
    input  logic [DATA_W-1:0] a_left,
    input  logic              a_left_valid,
    input  logic [DATA_W-1:0] b_top,
    input  logic              b_top_valid,
    output logic [DATA_W-1:0] a_right,
    output logic              a_right_valid,
    output logic [DATA_W-1:0] b_bottom,
    output logic              b_bottom_valid,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    // Product truncated to ACC_W bits gives the same modulo result for both signednesses
    always_comb begin
        a_ext = sign_mode ? {{(ACC_W-DATA_W){a_left[DATA_W-1]}}, a_left}
                          : {{(ACC_W-DATA_W){1'b0}}, a_left};
        b_ext = sign_mode ? {{(ACC_W-DATA_W){b_top[DATA_W-1]}}, b_top}
                          : {{(ACC_W-DATA_W){1'b0}}, b_top};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_right        <= '0;
            a_right_valid  <= 1'b0;
            b_bottom       <= '0;
            b_bottom_valid <= 1'b0;
            acc            <= '0;
        end else begin
            a_right        <= a_left;
            a_right_valid  <= a_left_valid;
            b_bottom       <= b_top;
            b_bottom_valid <= b_top_valid;
            if (clear) begin
                acc <= '0;
            end else if (a_left_valid && b_top_valid) begin
                acc <= acc + prod;
            end
        end
    end

endmodule

// File: rtl/mma_systolic_core.sv
// rtl/mma_systolic_core.sv - NxN output-stationary systolic core: handshake FSM, lane skew, drain, PE grid
module mma_systolic_core
    import mma_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_signed,
    input  logic                   cfg_accum,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [N*DATA_W-1:0]    a_col,
    input  logic [N*DATA_W-1:0]    b_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*ACC_W-1:0]   c_flat,
    output logic                   busy
);

    localparam int CW = drain_cnt_w(N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   drain_cnt;
    logic            sign_mode;
    logic            accept;
    logic            first_beat;
    logic            clear_acc;

    assign in_ready   = (state == IDLE) || (state == LOAD);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign first_beat = accept && (state == IDLE);
    assign clear_acc  = first_beat && !cfg_accum;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? DRAIN : LOAD;
            LOAD:    if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            sign_mode <= 1'b0;
        end else begin
            state <= state_nxt;
            if (first_beat) begin
                sign_mode <= cfg_signed;
            end
            // Counts edges since the last beat so the final PE MAC lands before DONE
            if (accept && in_last) begin
                drain_cnt <= '0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] a_bus   [N][N+1];
    logic              a_bus_v [N][N+1];
    logic [DATA_W-1:0] b_bus   [N+1][N];
    logic              b_bus_v [N+1][N];

    // Lane l waits l+1 cycles so row i and column j data meet at PE(i,j) together
    for (genvar l = 0; l < N; l++) begin : g_skew
        localparam int D = l + 1;
        logic [DATA_W-1:0] a_pipe   [D];
        logic              a_pipe_v [D];
        logic [DATA_W-1:0] b_pipe   [D];
        logic              b_pipe_v [D];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < D; s++) begin
                    a_pipe[s]   <= '0;
                    a_pipe_v[s] <= 1'b0;
                    b_pipe[s]   <= '0;
                    b_pipe_v[s] <= 1'b0;
                end
            end else begin
                a_pipe[0]   <= a_col[lane_lsb(l, DATA_W) +: DATA_W];
                a_pipe_v[0] <= accept;
                b_pipe[0]   <= b_row[lane_lsb(l, DATA_W) +: DATA_W];
                b_pipe_v[0] <= accept;
                for (int s = 1; s < D; s++) begin
                    a_pipe[s]   <= a_pipe[s-1];
                    a_pipe_v[s] <= a_pipe_v[s-1];
                    b_pipe[s]   <= b_pipe[s-1];
                    b_pipe_v[s] <= b_pipe_v[s-1];
                end
            end
        end

        assign a_bus[l][0]   = a_pipe[D-1];
        assign a_bus_v[l][0] = a_pipe_v[D-1];
        assign b_bus[0][l]   = b_pipe[D-1];
        assign b_bus_v[0][l] = b_pipe_v[D-1];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mma_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk            (clk),
                .rst            (rst),
                .clear          (clear_acc),
                .sign_mode      (sign_mode),
                .a_left         (a_bus[i][j]),
                .a_left_valid   (a_bus_v[i][j]),
                .b_top          (b_bus[i][j]),
                .b_top_valid    (b_bus_v[i][j]),
                .a_right        (a_bus[i][j+1]),
                .a_right_valid  (a_bus_v[i][j+1]),
                .b_bottom       (b_bus[i+1][j]),
                .b_bottom_valid (b_bus_v[i+1][j]),
                .acc            (c_flat[c_index(i, j, N)*ACC_W +: ACC_W])
            );
        end
    end

endmodule
